// File: rtl/gray_counter.sv
// rtl/gray_counter.sv - width-configurable binary/Gray up/down counter with load and saturation
// Gray output comes straight from a register so it can cross clock domains glitch-free.
module gray_counter #(
    parameter int WIDTH       = 4,
    parameter int RESET_VALUE = 0,
    parameter bit SATURATE    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] gray_next,
    output logic             wrap,
    output logic             sat
);

    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

    logic [WIDTH-1:0] bin_nxt;
    logic             wrap_nxt;
    logic             sat_nxt;
    logic             at_limit;

    assign at_limit = up ? (bin == {WIDTH{1'b1}}) : (bin == {WIDTH{1'b0}});

    always_comb begin
        bin_nxt  = bin;
        wrap_nxt = 1'b0;
        sat_nxt  = sat;
        if (rst) begin
            bin_nxt = RST_BIN;
            sat_nxt = 1'b0;
        end else if (load) begin
            bin_nxt = load_bin;
            sat_nxt = 1'b0;
        end else if (en) begin
            if (at_limit && SATURATE) begin
                sat_nxt = 1'b1;
            end else begin
                // modulo arithmetic gives the roll-over value for free
                sat_nxt  = 1'b0;
                wrap_nxt = at_limit;
                bin_nxt  = up ? bin + WIDTH'(1) : bin - WIDTH'(1);
            end
        end
    end

    assign gray_next = bin_nxt ^ (bin_nxt >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            bin  <= RST_BIN;
            gray <= RST_GRAY;
            wrap <= 1'b0;
            sat  <= 1'b0;
        end else begin
            bin  <= bin_nxt;
            gray <= gray_next;
            wrap <= wrap_nxt;
            sat  <= sat_nxt;
        end
    end

endmodule

// File: tb/tb_gray_counter.sv
// tb/tb_gray_counter.sv - self-checking bench for gray_counter across several parameter sets
module tb_gray_counter;

    localparam int ND = 6;

    function automatic int w_of(input int i);
        case (i)
            3:       return 2;
            4:       return 8;
            5:       return 16;
            default: return 4;
        endcase
    endfunction

    function automatic int rv_of(input int i);
        return (i == 2) ? 3 : 0;
    endfunction

    function automatic bit sat_of(input int i);
        return (i == 1);
    endfunction

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        up = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_bin = '0;

    logic [15:0] obin [ND];
    logic [15:0] ogray [ND];
    logic [15:0] ognext [ND];
    logic        owrap [ND];
    logic        osat [ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int W = w_of(g);
        logic [W-1:0] b, gr, gn;
        logic         w, s;
        gray_counter #(.WIDTH(W), .RESET_VALUE(rv_of(g)), .SATURATE(sat_of(g))) u_dut (
            .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
            .load_bin(load_bin[W-1:0]),
            .bin(b), .gray(gr), .gray_next(gn), .wrap(w), .sat(s)
        );
        assign obin[g]   = 16'(b);
        assign ogray[g]  = 16'(gr);
        assign ognext[g] = 16'(gn);
        assign owrap[g]  = w;
        assign osat[g]   = s;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", name, d, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0] b;
        logic [15:0] g;
        logic        w;
        logic        s;
    } exp_t;

    exp_t sbq[$];
    int   mb [ND];
    bit   ms [ND];

    // reference behaviour: unsigned modulo counter, optional clamp at the ends
    task automatic step(input logic r, input logic ld, input logic e, input logic u, input logic [15:0] lb);
        logic [15:0] gn_pre [ND];
        @(negedge clk);
        rst = r; load = ld; en = e; up = u; load_bin = lb;
        for (int g = 0; g < ND; g++) begin
            int   mask, nb;
            bit   nw, blocked;
            exp_t x;
            mask = (1 << w_of(g)) - 1;
            nb = mb[g];
            nw = 1'b0;
            if (r) begin
                nb = rv_of(g); ms[g] = 1'b0;
            end else if (ld) begin
                nb = int'(lb) & mask; ms[g] = 1'b0;
            end else if (e) begin
                blocked = sat_of(g) && (u ? (mb[g] == mask) : (mb[g] == 0));
                if (blocked) begin
                    ms[g] = 1'b1;
                end else begin
                    ms[g] = 1'b0;
                    nw = u ? (mb[g] == mask) : (mb[g] == 0);
                    nb = (u ? mb[g] + 1 : mb[g] - 1) & mask;
                end
            end
            mb[g] = nb;
            x.b = 16'(nb);
            x.g = 16'(nb ^ (nb >> 1));
            x.w = nw;
            x.s = ms[g];
            sbq.push_back(x);
        end
        #1;
        for (int g = 0; g < ND; g++) begin
            gn_pre[g] = ognext[g];
            chk("gray_next", g, 32'(ognext[g]), 32'(sbq[g].g));
        end
        @(posedge clk);
        #1;
        for (int g = 0; g < ND; g++) begin
            exp_t x;
            x = sbq.pop_front();
            chk("bin", g, 32'(obin[g]), 32'(x.b));
            chk("gray", g, 32'(ogray[g]), 32'(x.g));
            chk("wrap", g, 32'(owrap[g]), 32'(x.w));
            chk("sat", g, 32'(osat[g]), 32'(x.s));
            chk("gray_next_vs_gray", g, 32'(ogray[g]), 32'(gn_pre[g]));
        end
    endtask

    typedef struct {
        logic       r, ld, e, u;
        logic [3:0] lb;
        int         sel;
        logic [3:0] b, g;
        logic       w, s;
    } tv_t;

    tv_t tv [64];
    int  nv = 0;

    task automatic add(input logic r, input logic ld, input logic e, input logic u, input logic [3:0] lb,
                       input int sel, input logic [3:0] b, input logic [3:0] g, input logic w, input logic s);
        tv[nv] = '{r: r, ld: ld, e: e, u: u, lb: lb, sel: sel, b: b, g: g, w: w, s: s};
        nv++;
    endtask

    initial begin
        logic [15:0] prev [ND];
        int          since;
        bit          seen;

        // reset then full up-count, WIDTH=4
        add(1,0,0,0,0, 0, 4'd0,  4'b0000, 0, 0);
        add(1,0,0,0,0, 0, 4'd0,  4'b0000, 0, 0);
        add(0,0,1,1,0, 0, 4'd1,  4'b0001, 0, 0);
        add(0,0,1,1,0, 0, 4'd2,  4'b0011, 0, 0);
        add(0,0,1,1,0, 0, 4'd3,  4'b0010, 0, 0);
        add(0,0,1,1,0, 0, 4'd4,  4'b0110, 0, 0);
        add(0,0,1,1,0, 0, 4'd5,  4'b0111, 0, 0);
        add(0,0,1,1,0, 0, 4'd6,  4'b0101, 0, 0);
        add(0,0,1,1,0, 0, 4'd7,  4'b0100, 0, 0);
        add(0,0,1,1,0, 0, 4'd8,  4'b1100, 0, 0);
        add(0,0,1,1,0, 0, 4'd9,  4'b1101, 0, 0);
        add(0,0,1,1,0, 0, 4'd10, 4'b1111, 0, 0);
        add(0,0,1,1,0, 0, 4'd11, 4'b1110, 0, 0);
        add(0,0,1,1,0, 0, 4'd12, 4'b1010, 0, 0);
        add(0,0,1,1,0, 0, 4'd13, 4'b1011, 0, 0);
        add(0,0,1,1,0, 0, 4'd14, 4'b1001, 0, 0);
        add(0,0,1,1,0, 0, 4'd15, 4'b1000, 0, 0);
        add(0,0,1,1,0, 0, 4'd0,  4'b0000, 1, 0);
        // down wrap
        add(0,1,0,0,0, 0, 4'd0,  4'b0000, 0, 0);
        add(0,0,1,0,0, 0, 4'd15, 4'b1000, 1, 0);
        add(0,0,1,0,0, 0, 4'd14, 4'b1001, 0, 0);
        // saturation on the SATURATE=1 instance
        add(0,1,0,0,14, 1, 4'd14, 4'b1001, 0, 0);
        add(0,0,1,1,0,  1, 4'd15, 4'b1000, 0, 0);
        add(0,0,1,1,0,  1, 4'd15, 4'b1000, 0, 1);
        add(0,0,1,1,0,  1, 4'd15, 4'b1000, 0, 1);
        add(0,0,1,0,0,  1, 4'd14, 4'b1001, 0, 0);
        // priority: load over en, reset over load
        add(0,1,0,0,5, 0, 4'd5, 4'b0111, 0, 0);
        add(0,1,1,1,9, 0, 4'd9, 4'b1101, 0, 0);
        add(1,1,0,0,9, 0, 4'd0, 4'b0000, 0, 0);
        // mid-operation reset and hold with RESET_VALUE=3
        add(1,0,0,0,0, 2, 4'd3,  4'b0010, 0, 0);
        add(0,0,1,1,0, 2, 4'd4,  4'b0110, 0, 0);
        add(0,0,1,1,0, 2, 4'd5,  4'b0111, 0, 0);
        add(0,0,1,1,0, 2, 4'd6,  4'b0101, 0, 0);
        add(0,0,1,1,0, 2, 4'd7,  4'b0100, 0, 0);
        add(0,0,1,1,0, 2, 4'd8,  4'b1100, 0, 0);
        add(0,0,1,1,0, 2, 4'd9,  4'b1101, 0, 0);
        add(0,0,1,1,0, 2, 4'd10, 4'b1111, 0, 0);
        add(0,0,0,1,0, 2, 4'd10, 4'b1111, 0, 0);
        add(0,0,0,0,0, 2, 4'd10, 4'b1111, 0, 0);
        add(0,0,0,1,0, 2, 4'd10, 4'b1111, 0, 0);
        add(1,0,1,1,0, 2, 4'd3,  4'b0010, 0, 0);

        for (int i = 0; i < nv; i++) begin
            int s;
            step(tv[i].r, tv[i].ld, tv[i].e, tv[i].u, 16'(tv[i].lb));
            s = tv[i].sel;
            chk("tv_bin",  s, 32'(obin[s]),  32'(tv[i].b));
            chk("tv_gray", s, 32'(ogray[s]), 32'(tv[i].g));
            chk("tv_wrap", s, 32'(owrap[s]), 32'(tv[i].w));
            chk("tv_sat",  s, 32'(osat[s]),  32'(tv[i].s));
        end

        // free-running sweep for WIDTH=2/8/16
        step(1, 0, 0, 0, 16'h0);
        since = 0;
        seen  = 1'b0;
        for (int i = 0; i < 300; i++) begin
            for (int g = 3; g < ND; g++) prev[g] = ogray[g];
            step(0, 0, 1, 1, 16'h0);
            for (int g = 3; g < ND; g++)
                chk("one_bit_change", g, $countones(prev[g] ^ ogray[g]), 1);
            since++;
            if (owrap[3]) begin
                if (seen) chk("w2_wrap_period", 3, since, 4);
                seen  = 1'b1;
                since = 0;
            end
        end
        step(0, 1, 0, 0, 16'hFFF8);
        for (int i = 0; i < 20; i++) begin
            prev[5] = ogray[5];
            step(0, 0, 1, 1, 16'h0);
            chk("one_bit_change_w16", 5, $countones(prev[5] ^ ogray[5]), 1);
        end

        // random mix against the scoreboard model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Parametrised binary/Gray up/down counter. Generalises the 4-bit combinational binary-to-Gray mapping into a registered, width-configurable counter.
- Provides a glitch-free registered Gray output for clock-domain crossing, e.g. async FIFO read/write pointers.
- Adds synchronous load, count enable, direction select, optional saturation, and wrap/saturation status.
- Sits beside FIFO/CDC logic. Its Gray output is the only signal meant to cross clock domains.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..32.
- RESET_VALUE, 0, binary value loaded on reset; must be < 2**WIDTH.
- SATURATE, 0, 0 = modulo wrap-around, 1 = hold at the limit (all-ones going up, zero going down).

Ports:
- clk, input, 1, single clock; all state changes on its rising edge.
- rst, input, 1, synchronous active-high reset, sampled on rising edge of clk.
- en, input, 1, count enable; one step per cycle while high.
- up, input, 1, direction: 1 = increment, 0 = decrement; ignored when en=0.
- load, input, 1, synchronous load strobe; takes priority over en.
- load_bin, input, WIDTH, binary value captured when load=1.
- bin, output, WIDTH, registered binary count.
- gray, output, WIDTH, registered Gray code of bin: bin ^ (bin >> 1), register-driven, no output logic.
- gray_next, output, WIDTH, combinational Gray code of the value the registers take at the next edge.
- wrap, output, 1, registered one-cycle pulse on modulo roll-over.
- sat, output, 1, registered level; high while SATURATE=1 and the last enabled step was blocked at a limit.

Behaviour:
- Reset: rst=1 at an edge sets bin=RESET_VALUE, gray=RESET_VALUE^(RESET_VALUE>>1), wrap=0, sat=0. This overrides load and en. Reset mid-count takes effect at that edge; no partial update.
- Priority each edge: rst > load > en > hold.
- load=1: bin<=load_bin, gray<=Gray(load_bin), wrap<=0, sat<=0. Takes effect regardless of en or up.
- en=1, up=1:
  - Below all-ones: bin<=bin+1.
  - At all-ones, SATURATE=0: bin<=0, wrap<=1.
  - At all-ones, SATURATE=1: bin holds, sat<=1.
- en=1, up=0:
  - Above zero: bin<=bin-1.
  - At zero, SATURATE=0: bin<=all-ones, wrap<=1.
  - At zero, SATURATE=1: bin holds, sat<=1.
- en=1 with a step that is not blocked: sat<=0.
- en=0 and load=0: bin, gray and sat hold; wrap<=0.
- wrap is high for exactly one cycle per roll-over. Consecutive roll-overs (WIDTH=2 counting continuously) give a pulse every 4 cycles. wrap is never asserted when SATURATE=1.
- Latency: bin, gray, wrap and sat update at the edge following the inputs; one cycle from en/load to output.
- gray_next equals gray after the coming edge. It is computed from the next-state binary, including reset, load and saturation. It is for local comparison logic only, never for crossing clock domains.
- Invariant:
  - gray == bin ^ (bin >> 1) on every cycle.
  - Between two consecutive enabled, non-saturated steps, gray changes in exactly one bit, including across wrap.
  - A load may change gray in several bits.
- Arithmetic is unsigned modulo 2**WIDTH; no carry output. Direction changes take effect immediately, with no dead cycle.
- No X propagation: all outputs are defined from the first reset edge onward.

Test Plan:
- Reset then count: WIDTH=4, rst=1 for 2 cycles, then en=1, up=1 for 16 cycles -> gray sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000; wrap=1 only on the cycle bin returns to 0; one-bit change every step.
- Down wrap: load_bin=0 with load=1, then en=1, up=0 -> bin=15, gray=1000, wrap=1 for one cycle; next cycle bin=14, gray=1001, wrap=0.
- Saturation: SATURATE=1, load 4'b1110, en=1, up=1 for 3 cycles -> bin 15, 15, 15; gray=1000; sat=0, 1, 1; wrap stays 0. Then up=0 -> bin=14, sat=0.
- Priority: bin=5, then load=1, load_bin=9, en=1, up=1 in the same cycle -> bin=9, gray=1101. Next, rst=1 with load=1 -> bin=RESET_VALUE.
- Mid-operation reset and hold: RESET_VALUE=3, count up to bin=10, then en=0 for 3 cycles -> bin stays 10, gray=1111, wrap=0. Then rst=1 -> bin=3, gray=0010 at the next edge.
- Width sweep: WIDTH=2, 8 and 16, free-running up count -> gray_next always equals the next cycle's gray; the single-bit-change check passes over a full period; for WIDTH=2, wrap pulses every 4 cycles.
